// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch/PC-sequencing stage: FSM encodings,
// reset defaults and the branch-resolution flag bundles.
package fetch_unit_pkg;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic bltu;
    logic bgeu;
    logic jal;
    logic jalr;
  } br_flags_t;

  typedef struct packed {
    logic zero;
    logic lt;
    logic ltu;
  } cmp_flags_t;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC resolution: branch condition, jal/jalr targets,
// sequential fall-through. All adds wrap modulo 2^32.
module next_pc_unit
  import fetch_unit_pkg::*;
(
  input  br_flags_t   flags_i,
  input  cmp_flags_t  cmp_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_val_i,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o
);

  logic        taken;
  logic [31:0] jalr_tgt;

  assign taken = (flags_i.beq  &  cmp_i.zero) | (flags_i.bne  & ~cmp_i.zero) |
                 (flags_i.blt  &  cmp_i.lt)   | (flags_i.bge  & ~cmp_i.lt)   |
                 (flags_i.bltu &  cmp_i.ltu)  | (flags_i.bgeu & ~cmp_i.ltu);

  assign jalr_tgt = (rs1_val_i + imm_i) & ~32'h1;

  // jalr outranks jal, which outranks any branch
  always_comb begin
    if (flags_i.jalr)                 next_pc_o = jalr_tgt;
    else if (flags_i.jal || taken)    next_pc_o = pc_i + imm_i;
    else                              next_pc_o = pc_i + 32'd4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, handshakes with
// instruction memory and hands one instruction at a time to the back end.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        beq,
  input  logic        bne,
  input  logic        blt,
  input  logic        bge,
  input  logic        bltu,
  input  logic        bgeu,
  input  logic        jal,
  input  logic        jalr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        halt,
  output logic        halted,
  output logic        misaligned
);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        mis_q, mis_d;
  logic [31:0] next_pc;
  br_flags_t   flags;
  cmp_flags_t  cmp;

  assign flags = '{beq: beq, bne: bne, blt: blt, bge: bge,
                   bltu: bltu, bgeu: bgeu, jal: jal, jalr: jalr};
  assign cmp   = '{zero: zero, lt: lt, ltu: ltu};

  next_pc_unit u_next_pc (
    .flags_i   (flags),
    .cmp_i     (cmp),
    .imm_i     (imm),
    .rs1_val_i (rs1_val),
    .pc_i      (pc_q),
    .next_pc_o (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    mis_d   = mis_q;
    case (state_q)
      ST_RESET: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
          // halt masks the alignment fault; a faulting PC is never committed
          if (halt) begin
            state_d = ST_HALTED;
          end else if (next_pc[1]) begin
            mis_d   = 1'b1;
            state_d = ST_HALTED;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = (state_q == ST_ISSUE);
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign halted     = (state_q == ST_HALTED);
  assign misaligned = mis_q;

endmodule
